// File: rtl/config_writer.sv
// Assembles num_inputs+1 network words into a configuration frame and hands it
// to the tile config memory with a rdy/en/ack handshake, ack timeout and frame counter.
module config_writer #(
  parameter int width       = 16,
  parameter int num_inputs  = 8,
  parameter int ack_timeout = 255,
  parameter int cnt_width   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [width-1:0]     s_data,
  output logic                 s_ready,
  input  logic                 write_rdy,
  output logic                 write_en,
  output logic [width-1:0]     w_data_out [num_inputs:0],
  input  logic                 write_ack,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [cnt_width-1:0] frames_done
);

  localparam int IDX_W  = (num_inputs > 0) ? $clog2(num_inputs + 1) : 1;
  localparam int TCNT_W = $clog2(ack_timeout + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(num_inputs);
  localparam logic [TCNT_W-1:0] LAST_TCNT = TCNT_W'(ack_timeout - 1);

  typedef enum logic [1:0] {FILL, WAIT_RDY, WRITE, RELEASE} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [TCNT_W-1:0]    tcnt_reg, tcnt_next;
  logic                 write_en_reg, write_en_next;
  logic                 err_reg, err_next;
  logic [cnt_width-1:0] frames_reg, frames_next;
  logic                 accept;
  logic [width-1:0]     data_reg [num_inputs:0];

  assign accept      = s_valid && (state_reg == FILL);
  assign s_ready     = (state_reg == FILL);
  assign busy        = (state_reg != FILL);
  assign write_en    = write_en_reg;
  assign err_timeout = err_reg;
  assign frames_done = frames_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= FILL;
      idx_reg      <= '0;
      tcnt_reg     <= '0;
      write_en_reg <= 1'b0;
      err_reg      <= 1'b0;
      frames_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      tcnt_reg     <= tcnt_next;
      write_en_reg <= write_en_next;
      err_reg      <= err_next;
      frames_reg   <= frames_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    tcnt_next     = tcnt_reg;
    write_en_next = write_en_reg;
    err_next      = err_reg;
    frames_next   = frames_reg;
    case (state_reg)
      FILL: begin
        if (accept) begin
          // A new frame starting is the point where a past timeout is forgiven.
          if (idx_reg == '0) err_next = 1'b0;
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = WAIT_RDY;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      WAIT_RDY: begin
        if (write_rdy) begin
          write_en_next = 1'b1;
          tcnt_next     = '0;
          state_next    = WRITE;
        end
      end
      WRITE: begin
        // Ack is tested first so an ack on the last allowed cycle still counts.
        if (write_ack) begin
          write_en_next = 1'b0;
          frames_next   = frames_reg + cnt_width'(1);
          state_next    = RELEASE;
        end else if (tcnt_reg == LAST_TCNT) begin
          write_en_next = 1'b0;
          err_next      = 1'b1;
          state_next    = RELEASE;
        end else begin
          tcnt_next = tcnt_reg + TCNT_W'(1);
        end
      end
      RELEASE: state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  for (genvar gi = 0; gi <= num_inputs; gi++) begin : g_word
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_reg[gi] <= '0;
      end else if (accept && (idx_reg == IDX_W'(gi))) begin
        data_reg[gi] <= s_data;
      end
    end
    assign w_data_out[gi] = data_reg[gi];
  end

endmodule

// File: tb/tb_config_writer.sv
// Scoreboarded bench for config_writer: frames queued on send, compared when write_en rises.
module tb_config_writer;

  localparam int NI = 8;
  localparam int TO = 4;
  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic          s_valid;
  logic [15:0]   s_data;
  logic          s_ready;
  logic          write_rdy;
  logic          write_en;
  logic [15:0]   w_data_out [NI:0];
  logic          write_ack;
  logic          busy;
  logic          err_timeout;
  logic [CW-1:0] frames_done;

  config_writer #(.width(16), .num_inputs(NI), .ack_timeout(TO), .cnt_width(CW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .write_rdy(write_rdy), .write_en(write_en), .w_data_out(w_data_out),
    .write_ack(write_ack), .busy(busy), .err_timeout(err_timeout), .frames_done(frames_done)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   expq [$];
  logic [CW-1:0] exp_frames = '0;
  logic          exp_err = 1'b0;
  logic          prev_we = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Frame scoreboard: each write request must present the next queued frame.
  always @(negedge clk) begin
    if (write_en && !prev_we) begin
      check("frame_queue_depth", expq.size(), NI + 1);
      if (expq.size() >= NI + 1) begin
        for (int k = 0; k <= NI; k++) begin
          logic [15:0] w;
          w = expq.pop_front();
          check("frame_word", w_data_out[k], w);
        end
        $display("frame presented, frames_done=%0d", frames_done);
      end
    end
    prev_we = write_en;
  end

  task automatic send_frame(input logic [15:0] base, input logic hold, input logic [15:0] hold_data);
    for (int k = 0; k <= NI; k++) begin
      tick;
      check("fill_ready", s_ready, 1);
      if (k == 0) check("err_before_first", err_timeout, exp_err);
      if (k == 1) begin
        exp_err = 1'b0;
        check("err_after_first", err_timeout, exp_err);
      end
      s_valid = 1'b1;
      s_data  = base + 16'(k);
      expq.push_back(base + 16'(k));
    end
    tick;
    s_valid = hold;
    s_data  = hold_data;
    check("full_busy", busy, 1);
    check("full_ready", s_ready, 0);
  endtask

  // Caller has raised write_rdy while the frame waits; ack_cycle=0 means never ack.
  task automatic handshake(input int ack_cycle);
    int hi;
    int exp_hi;
    tick;
    write_rdy = 1'b0;
    check("we_rise", write_en, 1);
    hi = 0;
    for (int i = 0; i < 20 && write_en; i++) begin
      hi++;
      write_ack = (hi == ack_cycle);
      tick;
    end
    write_ack = 1'b0;
    if (ack_cycle > 0 && ack_cycle <= TO) begin
      exp_hi = ack_cycle;
      exp_frames = exp_frames + CW'(1);
    end else begin
      exp_hi = TO;
      exp_err = 1'b1;
    end
    check("we_high_cycles", hi, exp_hi);
    check("frames_done", frames_done, exp_frames);
    check("err_timeout", err_timeout, exp_err);
    check("release_ready", s_ready, 0);
    tick;
    check("ready_after_release", s_ready, 1);
    check("busy_after_release", busy, 0);
    $display("handshake ack_cycle=%0d high=%0d frames_done=%0d err=%0b", ack_cycle, hi, frames_done, err_timeout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; write_rdy = 1'b0; write_ack = 1'b0;
    repeat (3) tick;
    check("rst_ready", s_ready, 1);
    check("rst_we", write_en, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_frames", frames_done, 0);
    check("rst_word0", w_data_out[0], 0);
    reset = 1'b1;

    // basic frame
    send_frame(16'h0100, 1'b0, 16'h0);
    write_rdy = 1'b1;
    handshake(2);

    // backpressure with a held word that must not be captured
    send_frame(16'h0200, 1'b1, 16'hBEEF);
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_ready", s_ready, 0);
      check("bp_we", write_en, 0);
    end
    s_valid = 1'b0;
    write_rdy = 1'b1;
    handshake(2);

    // timeout, then tie on the final timeout cycle
    send_frame(16'h0300, 1'b0, 16'h0);
    write_rdy = 1'b1;
    handshake(0);
    send_frame(16'h0400, 1'b0, 16'h0);
    write_rdy = 1'b1;
    handshake(TO);

    // asynchronous reset during WRITE
    send_frame(16'h0500, 1'b0, 16'h0);
    write_rdy = 1'b1;
    tick;
    write_rdy = 1'b0;
    check("pre_reset_we", write_en, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_we", write_en, 0);
    check("async_rst_frames", frames_done, 0);
    check("async_rst_ready", s_ready, 1);
    for (int k = 0; k <= NI; k++) check("async_rst_word", w_data_out[k], 0);
    tick;
    reset = 1'b1;
    exp_frames = '0;
    exp_err = 1'b0;

    // counter wrap: 1,2,3,0,1
    for (int f = 0; f < 5; f++) begin
      send_frame(16'h0600 + 16'(f * 16), 1'b0, 16'h0);
      write_rdy = 1'b1;
      handshake(1 + (f % 2));
    end

    repeat (2) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
